pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipelined control unit for the 5-stage CPU. Decodes the 4-bit opcode in ID and carries EX, MEM and WB control bundles through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use and RAW hazards, flushes on taken branches, and runs a halt-drain state machine. Sits between the IF/ID register and the datapath stage registers, replacing the single-cycle decoder.

## Interface
Parameters:
- REG_AW, 4, register address width
- DRAIN, 3, cycles spent draining after HALT before `halted` asserts (range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  4  opcode in ID
- id_rs, id_rt  in  REG_AW each  source registers read in ID
- id_rd  in  REG_AW  destination register of the ID instruction
- ex_branch_taken  in  1  branch in EX resolved taken
- id_regsrc2  out  1  combinational: selects rd as second read port (SW/LHB/LLB)
- stall  out  1  freeze PC and IF/ID
- flush  out  1  squash IF/ID
- ex_ctrl  out  9  {RegDst[1:0], ALUSrc, ALUOp[2:0], SetFlags[2:0]} from ID/EX
- mem_ctrl  out  4  {MemRead, MemWrite, Branch, BranchReg} from EX/MEM
- wb_ctrl  out  2  {RegWrite, MemToReg} from MEM/WB
- wb_rd  out  REG_AW  destination register from MEM/WB
- halted  out  1  core halted; sticky until reset

## Operation
- Decode follows the ISA opcode map:
  - ADD/SUB: SetFlags 111.
  - XOR, SLL, SRA, ROR: SetFlags 100.
  - SLL, SRA, ROR, LW, SW, LHB, LLB: ALUSrc=1.
  - LW: MemRead and MemToReg.
  - SW: MemWrite, no RegWrite.
  - LHB/LLB: RegDst 11/10.
  - B: Branch. BR: Branch and BranchReg.
  - PCS: RegDst 00 with RegWrite.
  - HALT: no writes.
  - ALUOp equals opcode[2:0] for opcodes 0000–0111 and 000 otherwise.
- Bubble: all control bits zero and rd=0. A bubble enters ID/EX when `id_valid`=0, on a stall, on a flush, or in any state other than RUN.
- Hazard (RUN only): a stage "writes rd" when it has RegWrite set and rd≠0. Any RAW match is tested against id_rs or id_rt.
- Flush: `ex_branch_taken` gives flush=1 and a bubble into ID/EX. Flush overrides stall and overrides halt decode.
- FSM states: RUN → DRAIN → HALTED.
  - RUN→DRAIN: a valid HALT in ID with no stall and no flush. The HALT itself enters ID/EX as a bubble.
  - In DRAIN, a counter loads DRAIN-1 and decrements each cycle. stall=1 and bubbles are inserted.
  - DRAIN→HALTED: when the counter reaches 0.
  - In HALTED, stall=1 and halted=1. The only exit is reset.
- EX/MEM and MEM/WB always advance. They are never stalled.

## Timing
- Reset: all stage registers are bubbles, state=RUN, counter=0. stall, flush and halted are 0, and all control outputs are 0.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately, with no wait for a clock.
- Latency: an opcode decoded in cycle N appears on ex_ctrl at N+1, mem_ctrl at N+2, and wb_ctrl/wb_rd at N+3.
- stall and flush are combinational from current inputs and stage registers. They are valid in the same cycle.
- Load-use stall lasts exactly 1 cycle with forwarding, and at most 2 cycles without forwarding.
- `halted` rises DRAIN cycles after the edge that captured HALT.
- Simultaneous stall and flush in the same cycle: flush=1, stall=0.

## Configuration
- PIPE_CTRL_FWD_EN defined: the datapath forwards. Stall only when EX has MemRead and EX rd matches id_rs or id_rt.
- PIPE_CTRL_FWD_EN undefined: no forwarding. Stall when EX or MEM writes an rd matching id_rs or id_rt.

## Structure
- ctrl_pkg holds:
  - the opcode localparams (OP_ADD … OP_HALT);
  - packed typedefs ex_ctrl_t, mem_ctrl_t and wb_ctrl_t;
  - BUBBLE constants;
  - the FSM state enum.
- One sub-module, ctrl_decode: the purely combinational opcode→bundle decoder. pipe_ctrl instantiates it in ID.

## Test plan
- Reset, then ADD in ID at cycle 0 → ex_ctrl={01,0,000,111} at cycle 1; wb_ctrl=10 at cycle 3.
- LW r3 followed by ADD using r3 as rs (FWD_EN defined) → stall=1 for 1 cycle and one bubble in ID/EX. Without the macro → stall for 2 cycles.
- Match on r0 (LW r0, then use r0) → stall=0 in both configurations.
- ex_branch_taken=1 while LW-use stall is pending → flush=1, stall=0, ID/EX bubble.
- HALT with DRAIN=3 → stall=1 from the next cycle, halted=1 three cycles after capture and held. rst_n low mid-drain → all outputs 0 at once.
- HALT in ID with ex_branch_taken=1 → state stays RUN and halted never asserts.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode map, pipeline control bundle types and FSM states for the
// pipelined control unit (pipe_ctrl) and its ID-stage decoder (ctrl_decode).
package ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [2:0] set_flags;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic branch_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational ID-stage decoder: 4-bit opcode to EX/MEM/WB control
// bundles plus the second-read-port select.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [8:0] ex_ctrl,
  output logic [3:0] mem_ctrl,
  output logic [1:0] wb_ctrl,
  output logic       regsrc2
);

  ex_ctrl_t  dec_ex;
  mem_ctrl_t dec_mem;
  wb_ctrl_t  dec_wb;

  always_comb begin
    dec_ex  = EX_BUBBLE;
    dec_mem = MEM_BUBBLE;
    dec_wb  = WB_BUBBLE;
    regsrc2 = 1'b0;
    dec_ex.alu_op = opcode[3] ? 3'b000 : opcode[2:0];
    case (opcode)
      OP_ADD, OP_SUB: begin
        dec_ex.reg_dst   = 2'b01;
        dec_ex.set_flags = 3'b111;
        dec_wb.reg_write = 1'b1;
      end
      OP_XOR: begin
        dec_ex.reg_dst   = 2'b01;
        dec_ex.set_flags = 3'b100;
        dec_wb.reg_write = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        dec_ex.reg_dst   = 2'b01;
        dec_ex.alu_src   = 1'b1;
        dec_ex.set_flags = 3'b100;
        dec_wb.reg_write = 1'b1;
      end
      OP_RED, OP_PADDSB: begin
        dec_ex.reg_dst   = 2'b01;
        dec_wb.reg_write = 1'b1;
      end
      OP_LW: begin
        dec_ex.reg_dst    = 2'b01;
        dec_ex.alu_src    = 1'b1;
        dec_mem.mem_read  = 1'b1;
        dec_wb.reg_write  = 1'b1;
        dec_wb.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec_ex.alu_src    = 1'b1;
        dec_mem.mem_write = 1'b1;
        regsrc2           = 1'b1;
      end
      OP_LHB: begin
        dec_ex.reg_dst   = 2'b11;
        dec_ex.alu_src   = 1'b1;
        dec_wb.reg_write = 1'b1;
        regsrc2          = 1'b1;
      end
      OP_LLB: begin
        dec_ex.reg_dst   = 2'b10;
        dec_ex.alu_src   = 1'b1;
        dec_wb.reg_write = 1'b1;
        regsrc2          = 1'b1;
      end
      OP_B: dec_mem.branch = 1'b1;
      OP_BR: begin
        dec_mem.branch     = 1'b1;
        dec_mem.branch_reg = 1'b1;
      end
      OP_PCS: begin
        dec_ex.reg_dst   = 2'b00;
        dec_wb.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign ex_ctrl  = dec_ex;
  assign mem_ctrl = dec_mem;
  assign wb_ctrl  = dec_wb;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// hazard stall, branch flush and HALT drain FSM. PIPE_CTRL_FWD_EN = datapath forwards.
module pipe_ctrl
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int DRAIN  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              id_regsrc2,
  output logic              stall,
  output logic              flush,
  output logic [8:0]        ex_ctrl,
  output logic [3:0]        mem_ctrl,
  output logic [1:0]        wb_ctrl,
  output logic [REG_AW-1:0] wb_rd,
  output logic              halted
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN - 1);

  ex_ctrl_t  dec_ex;
  mem_ctrl_t dec_mem;
  wb_ctrl_t  dec_wb;

  ex_ctrl_t          idex_ex_q, idex_ex_d;
  mem_ctrl_t         idex_mem_q, idex_mem_d;
  wb_ctrl_t          idex_wb_q, idex_wb_d;
  logic [REG_AW-1:0] idex_rd_q, idex_rd_d;
  mem_ctrl_t         exmem_mem_q, exmem_mem_d;
  wb_ctrl_t          exmem_wb_q, exmem_wb_d;
  logic [REG_AW-1:0] exmem_rd_q, exmem_rd_d;
  wb_ctrl_t          memwb_wb_q, memwb_wb_d;
  logic [REG_AW-1:0] memwb_rd_q, memwb_rd_d;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  logic ex_match;
  logic hazard;
  logic insert_bubble;

  ctrl_decode u_decode (
    .opcode   (id_opcode),
    .ex_ctrl  (dec_ex),
    .mem_ctrl (dec_mem),
    .wb_ctrl  (dec_wb),
    .regsrc2  (id_regsrc2)
  );

  assign ex_match = idex_wb_q.reg_write && (idex_rd_q != '0) &&
                    ((idex_rd_q == id_rs) || (idex_rd_q == id_rt));

`ifdef PIPE_CTRL_FWD_EN
  // Forwarding covers everything except a load whose data is not ready until MEM.
  assign hazard = ex_match && idex_mem_q.mem_read;
`else
  logic mem_match;
  assign mem_match = exmem_wb_q.reg_write && (exmem_rd_q != '0) &&
                     ((exmem_rd_q == id_rs) || (exmem_rd_q == id_rt));
  assign hazard = ex_match || mem_match;
`endif

  always_comb begin
    flush         = 1'b0;
    stall         = 1'b0;
    insert_bubble = 1'b1;
    state_d       = state_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_RUN: begin
        flush = ex_branch_taken;
        stall = hazard && !ex_branch_taken;
        if (id_valid && !stall && !flush) begin
          if (id_opcode == OP_HALT) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            insert_bubble = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_HALTED;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_HALTED: stall = 1'b1;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    idex_ex_d   = insert_bubble ? EX_BUBBLE  : dec_ex;
    idex_mem_d  = insert_bubble ? MEM_BUBBLE : dec_mem;
    idex_wb_d   = insert_bubble ? WB_BUBBLE  : dec_wb;
    idex_rd_d   = insert_bubble ? '0         : id_rd;
    exmem_mem_d = idex_mem_q;
    exmem_wb_d  = idex_wb_q;
    exmem_rd_d  = idex_rd_q;
    memwb_wb_d  = exmem_wb_q;
    memwb_rd_d  = exmem_rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ex_q   <= EX_BUBBLE;
      idex_mem_q  <= MEM_BUBBLE;
      idex_wb_q   <= WB_BUBBLE;
      idex_rd_q   <= '0;
      exmem_mem_q <= MEM_BUBBLE;
      exmem_wb_q  <= WB_BUBBLE;
      exmem_rd_q  <= '0;
      memwb_wb_q  <= WB_BUBBLE;
      memwb_rd_q  <= '0;
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
    end else begin
      idex_ex_q   <= idex_ex_d;
      idex_mem_q  <= idex_mem_d;
      idex_wb_q   <= idex_wb_d;
      idex_rd_q   <= idex_rd_d;
      exmem_mem_q <= exmem_mem_d;
      exmem_wb_q  <= exmem_wb_d;
      exmem_rd_q  <= exmem_rd_d;
      memwb_wb_q  <= memwb_wb_d;
      memwb_rd_q  <= memwb_rd_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_ctrl  = idex_ex_q;
  assign mem_ctrl = exmem_mem_q;
  assign wb_ctrl  = memwb_wb_q;
  assign wb_rd    = memwb_rd_q;
  assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector tables for decode, hazards, flush
// and HALT drain, a stage scoreboard queue, and async-reset corner cases.
module tb_pipe_ctrl;

  localparam int REG_AW = 4;
  localparam int DRAIN  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [3:0]        id_opcode;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              ex_branch_taken;
  logic              id_regsrc2, stall, flush, halted;
  logic [8:0]        ex_ctrl;
  logic [3:0]        mem_ctrl;
  logic [1:0]        wb_ctrl;
  logic [REG_AW-1:0] wb_rd;

  typedef struct {
    logic              valid;
    logic [3:0]        op;
    logic [REG_AW-1:0] rs, rt, rd;
    logic              br;
    logic              stall, flush, halted;
  } vec_t;

  typedef struct packed {
    logic [8:0]        ex;
    logic [3:0]        mem;
    logic [1:0]        wb;
    logic [REG_AW-1:0] rd;
  } stage_t;

  vec_t   tbl[$];
  stage_t sb_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  pipe_ctrl #(.REG_AW(REG_AW), .DRAIN(DRAIN)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .ex_branch_taken (ex_branch_taken),
    .id_regsrc2      (id_regsrc2),
    .stall           (stall),
    .flush           (flush),
    .ex_ctrl         (ex_ctrl),
    .mem_ctrl        (mem_ctrl),
    .wb_ctrl         (wb_ctrl),
    .wb_rd           (wb_rd),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference ISA decode table, written out as literal bundles.
  function automatic stage_t golden(input logic [3:0] op, input logic [REG_AW-1:0] rd);
    stage_t s;
    s = '0;
    s.rd = rd;
    case (op)
      4'h0: begin s.ex = 9'b01_0_000_111; s.wb = 2'b10; end
      4'h1: begin s.ex = 9'b01_0_001_111; s.wb = 2'b10; end
      4'h2: begin s.ex = 9'b01_0_010_100; s.wb = 2'b10; end
      4'h4: begin s.ex = 9'b01_1_100_100; s.wb = 2'b10; end
      4'h5: begin s.ex = 9'b01_1_101_100; s.wb = 2'b10; end
      4'h6: begin s.ex = 9'b01_1_110_100; s.wb = 2'b10; end
      4'h8: begin s.ex = 9'b01_1_000_000; s.mem = 4'b1000; s.wb = 2'b11; end
      4'h9: begin s.ex = 9'b00_1_000_000; s.mem = 4'b0100; end
      4'hA: begin s.ex = 9'b11_1_000_000; s.wb = 2'b10; end
      4'hB: begin s.ex = 9'b10_1_000_000; s.wb = 2'b10; end
      4'hC: s.mem = 4'b0010;
      4'hD: s.mem = 4'b0011;
      4'hE: s.wb = 2'b10;
      default: s.ex = 9'b0;
    endcase
    return s;
  endfunction

  function automatic logic exp_src2(input logic [3:0] op);
    return (op == 4'h9) || (op == 4'hA) || (op == 4'hB);
  endfunction

  task automatic add(input logic v, input logic [3:0] op, input logic [REG_AW-1:0] rs,
                     input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                     input logic br, input logic st, input logic fl, input logic hl);
    vec_t e;
    e.valid = v; e.op = op; e.rs = rs; e.rt = rt; e.rd = rd;
    e.br = br; e.stall = st; e.flush = fl; e.halted = hl;
    tbl.push_back(e);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 4'h0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic resetQueue();
    sb_q.delete();
    for (int i = 0; i < 3; i++) sb_q.push_back('0);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    stage_t nxt, dropped;
    @(negedge clk);
    id_valid = v.valid; id_opcode = v.op;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    ex_branch_taken = v.br;
    #2;
    checkOutput({tag, " stall"},  16'(stall),      16'(v.stall));
    checkOutput({tag, " flush"},  16'(flush),      16'(v.flush));
    checkOutput({tag, " halted"}, 16'(halted),     16'(v.halted));
    checkOutput({tag, " src2"},   16'(id_regsrc2), 16'(exp_src2(v.op)));
    checkOutput({tag, " ex"},     16'(ex_ctrl),    16'(sb_q[2].ex));
    checkOutput({tag, " mem"},    16'(mem_ctrl),   16'(sb_q[1].mem));
    checkOutput({tag, " wb"},     16'(wb_ctrl),    16'(sb_q[0].wb));
    checkOutput({tag, " wb_rd"},  16'(wb_rd),      16'(sb_q[0].rd));
    nxt = (v.valid && !v.stall && !v.flush && v.op != 4'hF) ? golden(v.op, v.rd) : '0;
    sb_q.push_back(nxt);
    dropped = sb_q.pop_front();
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  task automatic checkZero(input string tag);
    id_valid = 1'b0; id_opcode = 4'h0; id_rs = '0; id_rt = '0; id_rd = '0;
    ex_branch_taken = 1'b0;
    #1;
    checkOutput({tag, " stall"},  16'(stall),      16'd0);
    checkOutput({tag, " flush"},  16'(flush),      16'd0);
    checkOutput({tag, " halted"}, 16'(halted),     16'd0);
    checkOutput({tag, " src2"},   16'(id_regsrc2), 16'd0);
    checkOutput({tag, " ex"},     16'(ex_ctrl),    16'd0);
    checkOutput({tag, " mem"},    16'(mem_ctrl),   16'd0);
    checkOutput({tag, " wb"},     16'(wb_ctrl),    16'd0);
    checkOutput({tag, " wb_rd"},  16'(wb_rd),      16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    resetQueue();
    repeat (2) @(negedge clk);
    checkZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep: sources r8..r15, destinations r1..r7, so no hazards.
    add(1, 4'h0,  8,  9, 1, 0, 0, 0, 0);
    add(1, 4'h1,  8,  9, 2, 0, 0, 0, 0);
    add(1, 4'h2, 10, 11, 3, 0, 0, 0, 0);
    add(1, 4'h4, 12, 13, 4, 0, 0, 0, 0);
    add(1, 4'h5, 14, 15, 5, 0, 0, 0, 0);
    add(1, 4'h6,  8,  9, 6, 0, 0, 0, 0);
    add(1, 4'h8, 10, 11, 7, 0, 0, 0, 0);
    add(1, 4'h9, 12, 13, 1, 0, 0, 0, 0);
    add(1, 4'hA, 14, 15, 2, 0, 0, 0, 0);
    add(1, 4'hB,  8,  9, 3, 0, 0, 0, 0);
    add(1, 4'hE, 10, 11, 4, 0, 0, 0, 0);
    add(1, 4'hC, 12, 13, 5, 0, 0, 0, 0);
    add(1, 4'hD, 14, 15, 6, 0, 0, 0, 0);
    add(0, 4'h0,  8,  9, 7, 0, 0, 0, 0);
    nops(3);
    // Load-use on rs.
    add(1, 4'h8,  8,  9, 3, 0, 0, 0, 0);
    add(1, 4'h0,  3, 10, 4, 0, 1, 0, 0);
`ifdef PIPE_CTRL_FWD_EN
    add(1, 4'h0,  3, 10, 4, 0, 0, 0, 0);
`else
    add(1, 4'h0,  3, 10, 4, 0, 1, 0, 0);
    add(1, 4'h0,  3, 10, 4, 0, 0, 0, 0);
`endif
    nops(3);
    // ALU-to-ALU dependency on rt.
    add(1, 4'h0,  8,  9, 5, 0, 0, 0, 0);
`ifdef PIPE_CTRL_FWD_EN
    add(1, 4'h2, 10,  5, 6, 0, 0, 0, 0);
`else
    add(1, 4'h2, 10,  5, 6, 0, 1, 0, 0);
    add(1, 4'h2, 10,  5, 6, 0, 1, 0, 0);
    add(1, 4'h2, 10,  5, 6, 0, 0, 0, 0);
`endif
    nops(3);
    // r0 never creates a hazard.
    add(1, 4'h8,  8,  9, 0, 0, 0, 0, 0);
    add(1, 4'h0,  0,  0, 4, 0, 0, 0, 0);
    nops(3);
    // Flush wins over a pending load-use stall.
    add(1, 4'h8,  8,  9, 3, 0, 0, 0, 0);
    add(1, 4'h0,  3, 10, 4, 1, 0, 1, 0);
    nops(3);
    // Flush overrides HALT decode; pipeline keeps running.
    add(1, 4'hF,  0,  0, 0, 1, 0, 1, 0);
    add(1, 4'h0,  8,  9, 1, 0, 0, 0, 0);
    nops(3);
    // HALT: three drain cycles, then halted held.
    add(1, 4'hF,  0,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 4'h0, 8, 9, 2, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 4'h0, 8, 9, 2, 0, 1, 0, 1);
    runTable("main");

    #1 rst_n = 1'b0;
    checkZero("rst_halted");
    @(negedge clk);
    rst_n = 1'b1;
    resetQueue();

    add(1, 4'hF,  0,  0, 0, 0, 0, 0, 0);
    add(1, 4'h0,  8,  9, 2, 0, 1, 0, 0);
    runTable("drain");

    #1 rst_n = 1'b0;
    checkZero("rst_drain");
    @(negedge clk);
    rst_n = 1'b1;
    resetQueue();

    add(1, 4'h0,  8,  9, 1, 0, 0, 0, 0);
    nops(3);
    runTable("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
